// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// Holds the loader state enum, word size and the length field type.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [15:0] len_t;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words.
// Ports: byte_vld/byte_in strobe in, clear restarts; word/word_valid on 4th byte.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] IDX_LAST = 2'(WORD_BYTES - 1);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] part_q, part_d;

  // The last lane comes straight from the input so the word is
  // available in the same cycle as the 4th byte.
  always_comb begin
    idx_d      = idx_q;
    part_d     = part_q;
    word       = {byte_in, part_q};
    word_valid = 1'b0;
    if (clear) begin
      idx_d  = '0;
      part_d = '0;
    end else if (byte_vld) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0: part_d[7:0]   = byte_in;
        2'd1: part_d[15:8]  = byte_in;
        2'd2: part_d[23:16] = byte_in;
        default: begin
          word_valid = (idx_q == IDX_LAST);
          part_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      part_q <= '0;
    end else begin
      idx_q  <= idx_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length/data/checksum byte frame into instruction memory.
// Ports: byte stream in (valid/ready), imem write port out, core reset/status out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  localparam len_t DEPTH_LEN = len_t'(DEPTH_WORDS);

  state_t            state_q, state_d;
  len_t              len_q, len_d;
  len_t              cnt_q, cnt_d;
  len_t              len_in;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rdy_st;
  logic              accept;
  logic              asm_vld;
  logic              word_vld;
  logic [31:0]       asm_word;

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .byte_vld   (asm_vld),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_valid (word_vld)
  );

  // load_start has priority: a byte offered alongside it is not taken.
  assign rdy_st = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
  assign in_ready = rdy_st && !load_start;
  assign accept   = in_valid && in_ready;
  assign asm_vld  = accept && (state_q == S_DATA);
  assign len_in   = {in_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load_start) begin
      state_d = S_LEN0;
      len_d   = '0;
      cnt_d   = '0;
      csum_d  = '0;
      addr_d  = '0;
      wdata_d = '0;
    end else if (accept) begin
      unique case (state_q)
        S_LEN0: begin
          len_d   = {8'h00, in_data};
          state_d = S_LEN1;
        end
        S_LEN1: begin
          len_d = len_in;
          if (len_in > DEPTH_LEN) state_d = S_ERR;
          else if (len_in == '0)  state_d = S_CSUM;
          else                    state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ in_data;
          if (word_vld) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'({cnt_q, 2'b00});
            wdata_d = asm_word;
            cnt_d   = cnt_q + 16'd1;
            if (cnt_d == len_q) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cpu_rst_n  = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Compares writes and status against a frame-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [63:0] wq[$];
  logic [63:0] exp_w[$];
  int          exp_res;

  imem_loader #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (imem_we) wq.push_back({imem_addr, imem_wdata});

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Frame rules: 16-bit LE count, 4*N LE data bytes, XOR checksum.
  // exp_res: 0 = still loading, 1 = done, 2 = error.
  task automatic model(input logic [7:0] q[$]);
    int n;
    logic [7:0] cs;
    exp_w.delete();
    exp_res = 0;
    cs = 8'h00;
    if (q.size() < 2) return;
    n = int'(q[0]) + 256 * int'(q[1]);
    if (n > 64) begin
      exp_res = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      int b;
      b = 2 + 4 * i;
      if (q.size() < b + 4) return;
      exp_w.push_back({32'(4 * i),
                       q[b+3], q[b+2], q[b+1], q[b]});
      cs = cs ^ q[b] ^ q[b+1] ^ q[b+2] ^ q[b+3];
    end
    if (q.size() > 2 + 4 * n)
      exp_res = (q[2 + 4 * n] == cs) ? 1 : 2;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    in_valid   = 1'(($urandom & 1));
    in_data    = 8'($urandom);
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    wq.delete();
  endtask

  task automatic send(input logic [7:0] q[$], input int maxbub);
    foreach (q[i]) begin
      int nb;
      nb = (maxbub > 0) ? int'($urandom_range(maxbub, 1)) : 0;
      if (i == 0) nb = 0;
      for (int k = 0; k < nb; k++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = q[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Status is checked in the cycle right after the last byte;
  // writes are checked after the pipeline has drained.
  task automatic check_run(input logic [7:0] q[$], input string nm);
    model(q);
    checks++;
    if (done !== (exp_res == 1) || error !== (exp_res == 2) ||
        cpu_rst_n !== (exp_res == 1) ||
        in_ready !== (exp_res == 0)) begin
      errors++;
      $display("FAIL %s status: done=%b err=%b crst=%b rdy=%b need res=%0d",
               nm, done, error, cpu_rst_n, in_ready, exp_res);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() !== exp_w.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d need %0d",
               nm, wq.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (wq[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL %s write %0d: got %h need %h",
                   nm, i, wq[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic run(input logic [7:0] q[$], input int mb,
                     input string nm);
    pulse_start();
    send(q, mb);
    check_run(q, nm);
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 32'h0 ||
        imem_wdata !== 32'h0 || cpu_rst_n !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b",
               nm, in_ready, imem_we, imem_addr, imem_wdata,
               cpu_rst_n, done, error);
    end
  endtask

  logic [7:0] good[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                          8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after reset");
  endtask

  task automatic test_good();
    run(good, 0, "good");
    checks++;
    if (wq.size() != 2 || wq[0] !== 64'h00000000_00500093 ||
        wq[1] !== 64'h00000004_00A00113) begin
      errors++;
      $display("FAIL good literal writes: got %0d writes, first %h",
               wq.size(), (wq.size() > 0) ? wq[0] : 64'h0);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] q[$];
    q = good;
    q[10] = 8'h70;
    run(q, 0, "bad_csum");
  endtask

  task automatic test_overflow();
    logic [7:0] q[$] = '{8'h41, 8'h00};
    run(q, 0, "overflow");
    // Further bytes must be refused once in error.
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wq.size() != 0 || error !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow hold: writes=%0d err=%b rdy=%b need 0 1 0",
               wq.size(), error, in_ready);
    end
  endtask

  task automatic test_zero();
    logic [7:0] q[$] = '{8'h00, 8'h00, 8'h00};
    run(q, 0, "zero_len");
  endtask

  task automatic test_bubbles();
    for (int r = 0; r < 3; r++) run(good, 3, "bubbles");
  endtask

  task automatic test_abort_start();
    logic [7:0] pre[$];
    for (int i = 0; i < 8; i++) pre.push_back(good[i]);
    run(pre, 0, "abort_prefix");
    run(good, 0, "abort_restart");
  endtask

  task automatic test_abort_reset();
    logic [7:0] pre[$];
    for (int i = 0; i < 8; i++) pre.push_back(good[i]);
    run(pre, 0, "rst_prefix");
    wq.delete();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid reset 1");
    @(negedge clk);
    check_reset_vals("mid reset 2");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("post mid reset");
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL partial word written: got %0d writes need 0",
               wq.size());
    end
    run(good, 0, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      logic [7:0] q[$];
      int n;
      logic [7:0] cs;
      cs = 8'h00;
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(300, 65))
                                      : int'($urandom_range(9, 0));
      if (r == 0) n = 64;
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      if (n <= 64) begin
        for (int i = 0; i < 4 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          cs = cs ^ b;
          q.push_back(b);
        end
        if ($urandom_range(3, 0) == 0) q.push_back(cs ^ 8'(1 << $urandom_range(7, 0)));
        else q.push_back(cs);
      end
      run(q, $urandom_range(2, 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_overflow();
    test_zero();
    test_bubbles();
    test_abort_start();
    test_abort_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into little-endian 32-bit instruction words and writes them to word-aligned byte addresses 0, 4, 8, …
- Holds the core in reset until the whole image has loaded and the checksum matches.
- Sits between the host link (UART/debug byte stream) and the instruction memory write port. The core's fetch side reads the same memory by PC.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words.
- ADDR_W, 32, width of imem_addr (byte address, matches PC width).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse: abort anything in progress and begin a new load.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  single-cycle write strobe to the instruction memory.
- imem_addr  out  ADDR_W  byte address of the write, always a multiple of 4.
- imem_wdata  out  32  instruction word.
- cpu_rst_n  out  1  active-low reset to the core; low while loading or after an error.
- done  out  1  image loaded and checksum OK.
- error  out  1  length overflow or checksum mismatch.

Behaviour:
- Reset values (async, rst_n=0):
  - state=S_LEN0.
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst_n=0, done=0, error=0.
  - Internal counters and checksum are 0.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N data bytes, least significant byte first within each word.
  - CSUM: XOR of all data bytes only; the length bytes are excluded.
- States and transitions:
  - S_LEN0: accept LEN_LO, then go to S_LEN1.
  - S_LEN1: accept LEN_HI.
    - N > DEPTH_WORDS → S_ERR.
    - N == 0 → S_CSUM.
    - Otherwise → S_DATA.
  - S_DATA: accept bytes; a 2-bit byte index selects the lane.
    - Every byte is XORed into the running checksum.
    - On the 4th byte, register the word and pulse the write. Word count reaching N → S_CSUM, otherwise stay.
  - S_CSUM: accept one byte. Equal to the running XOR → S_DONE, otherwise → S_ERR.
  - S_DONE: in_ready=0, done=1, cpu_rst_n=1. All three are registered and become valid the cycle after the CSUM byte is accepted.
  - S_ERR: in_ready=0, error=1, cpu_rst_n=0.
- Write timing:
  - imem_we is high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - imem_addr = 4*word_index and imem_wdata are stable in that same cycle.
  - word_index increments after each write.
  - No backpressure is needed because the memory accepts a write every cycle. in_ready stays 1 in S_LEN0/S_LEN1/S_DATA/S_CSUM.
- Bubbles: cycles with in_valid=0 change no state and no counters.
- load_start:
  - From any state, the next state is S_LEN0.
  - Clears the counters, checksum and partial word.
  - Sets cpu_rst_n=0, done=0, error=0.
  - If a byte is offered in the same cycle, load_start wins and the byte is discarded (not accepted).
- Addressing: N ≤ DEPTH_WORDS is checked before any write, so addresses never wrap or exceed 4*(DEPTH_WORDS-1).
- Mid-operation reset: rst_n low at any time immediately forces the reset values. A partially assembled word is never written.

Decomposition:
- imem_loader_pkg holds:
  - the state enum (S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR);
  - constant WORD_BYTES=4;
  - typedef for the 16-bit length field.
- One sub-module, byte_word_assembler, is natural:
  - Inputs: byte strobe, byte, clear.
  - Outputs: 32-bit word plus a word_valid pulse on the 4th byte.
  - The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Bytes 02 00 93 00 50 00 13 01 A0 00 71, in_valid held high → imem_we pulses twice: (addr 0x0, 0x00500093) and (addr 0x4, 0x00A00113). Then done=1, cpu_rst_n=1, in_ready=0, error=0.
- Same stream with the last byte 0x70 → the same two writes occur, then error=1, done=0, cpu_rst_n stays 0.
- Bytes 41 00 (N=65 > 64) → error=1 the cycle after LEN_HI; no imem_we ever; in_ready=0.
- Bytes 00 00 00 → done=1, zero writes.
- Stream from scenario 1 with in_valid deasserted for 1-3 random cycles between bytes → identical writes and final outputs.
- Scenario 1 interrupted after 6 data bytes:
  - by a load_start pulse, then the full stream → exactly two writes, addresses restart at 0x0;
  - separately, by rst_n low for 2 cycles → all outputs at reset values and no write of the partial word.
